// File: rtl/calyx_div_pkg.sv
// Shared types and helpers for the multi-cycle divider family.
//   div_state_t : FSM encoding used by std_div_pipe.
//   div_cnt_w() : width of the step counter for a WIDTH-bit divide.
package calyx_div_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  // Counter must hold 0..WIDTH-1; never narrower than one bit.
  function automatic int div_cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/std_div_step.sv
// One restoring-division step (combinational).
//   acc          : partial remainder going in (always < divisor)
//   dividend_msb : next dividend bit shifted into the remainder
//   divisor      : divisor
//   next_acc     : partial remainder coming out
//   q_bit        : quotient bit produced by this step
module std_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_acc,
  output logic             q_bit
);

  // One extra bit so a set acc MSB survives the shift.
  logic [WIDTH:0] t;

  assign t     = {acc, dividend_msb};
  assign q_bit = (t >= {1'b0, divisor});
  // When t >= divisor the true difference is below divisor, so the
  // modulo-2^WIDTH subtraction of the low bits is exact.
  assign next_acc = q_bit ? (t[WIDTH-1:0] - divisor) : t[WIDTH-1:0];

endmodule

// File: rtl/std_div_pipe.sv
// Multi-cycle unsigned divider with go/done handshake.
// Restoring division, one quotient bit per cycle; divide-by-zero takes a
// one-cycle fast path returning all-ones quotient and remainder = left.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   go              : start request, sampled only in IDLE
//   left, right     : dividend / divisor, captured on the accepting edge
//   out_quotient    : registered quotient, updated only on entry to DONE
//   out_remainder   : registered remainder, updated only on entry to DONE
//   done            : one-cycle completion pulse (high exactly in DONE)
module std_div_pipe
  import calyx_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done
);

  localparam int CW = div_cnt_w(WIDTH);

  div_state_t       state;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             q_bit;

  std_div_step #(.WIDTH(WIDTH)) u_step (
    .acc          (acc),
    .dividend_msb (dividend[WIDTH-1]),
    .divisor      (divisor),
    .next_acc     (acc_nxt),
    .q_bit        (q_bit)
  );

  assign quo_nxt = (quo << 1) | WIDTH'(q_bit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      dividend      <= '0;
      divisor       <= '0;
      acc           <= '0;
      quo           <= '0;
      count         <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (go) begin
            if (right != '0) begin
              dividend <= left;
              divisor  <= right;
              acc      <= '0;
              quo      <= '0;
              count    <= '0;
              state    <= BUSY;
            end else begin
              out_quotient  <= '1;
              out_remainder <= left;
              done          <= 1'b1;
              state         <= DONE;
            end
          end
        end
        BUSY: begin
          acc      <= acc_nxt;
          quo      <= quo_nxt;
          dividend <= dividend << 1;
          count    <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            out_quotient  <= quo_nxt;
            out_remainder <= acc_nxt;
            done          <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Protocol misuse warning only; go is ignored while BUSY.
  always @(posedge clk) begin
    if (!reset && state == BUSY && go)
      $error("std_div_pipe: go asserted while BUSY");
  end

endmodule

// File: tb/tb_std_div_pipe.sv
module tb_std_div_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         go;
  logic [W-1:0] left, right;
  logic [W-1:0] out_quotient, out_remainder;
  logic         done;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] prev_q = '0;
  logic [W-1:0] prev_r = '0;

  always #5 clk = ~clk;

  std_div_pipe #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .go            (go),
    .left          (left),
    .right         (right),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .done          (done)
  );

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic [W-1:0] q;
    logic [W-1:0] rem;
    int           lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer division with the divide-by-zero convention.
  function automatic logic [W-1:0] ref_q(input logic [W-1:0] l, input logic [W-1:0] r);
    return (r == 0) ? {W{1'b1}} : l / r;
  endfunction
  function automatic logic [W-1:0] ref_r(input logic [W-1:0] l, input logic [W-1:0] r);
    return (r == 0) ? l : l % r;
  endfunction

  // Present go with operands in cycle 0; returns #1 into cycle 1.
  task automatic issue(input logic [W-1:0] l, input logic [W-1:0] r);
    @(posedge clk); #1;
    go = 1'b1; left = l; right = r;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  // Scan cycles from start_n; returns at negedge of the done cycle.
  task automatic wait_done(input int start_n, output int lat);
    int  n;
    bit  hold_ok;
    n = start_n; hold_ok = 1'b1; lat = -1;
    while (n <= 80) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
      if (out_quotient !== prev_q || out_remainder !== prev_r) hold_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk("outputs_hold_before_done", hold_ok, 1);
  endtask

  task automatic check_result(input string nm, input logic [W-1:0] q, input logic [W-1:0] r,
                              input int lat, input int exp_lat);
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_quotient"}, out_quotient, q);
    chk({nm, "_remainder"}, out_remainder, r);
    prev_q = q; prev_r = r;
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, done, 0);
    chk({nm, "_hold_after"}, {out_quotient, out_remainder}, {q, r});
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] l, input logic [W-1:0] r,
                        input logic [W-1:0] q, input logic [W-1:0] rem, input int exp_lat);
    int lat;
    issue(l, r);
    wait_done(1, lat);
    check_result(nm, q, rem, lat, exp_lat);
  endtask

  vec_t vecs[$];

  initial begin
    int lat, abs_cyc, base;
    logic [W-1:0] rl, rr;

    reset = 1'b1; go = 1'b0; left = '0; right = '0;
    vecs.push_back('{32'd100,        32'd7,          32'd14,         32'd2,          33});
    vecs.push_back('{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1});
    vecs.push_back('{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33});
    vecs.push_back('{32'd3,          32'h8000_0000,  32'd0,          32'd3,          33});
    vecs.push_back('{32'd50,         32'd5,          32'd10,         32'd0,          33});
    vecs.push_back('{32'd0,          32'd3,          32'd0,          32'd0,          33});
    vecs.push_back('{32'd7,          32'd100,        32'd0,          32'd7,          33});
    vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          33});
    vecs.push_back('{32'h8000_0000,  32'd3,          32'd715827882,  32'd2,          33});
    vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          32'd1,          33});
    vecs.push_back('{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1});

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_quotient", out_quotient, 0);
    chk("reset_remainder", out_remainder, 0);
    chk("reset_done", done, 0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].l, vecs[i].r, vecs[i].q, vecs[i].rem, vecs[i].lat);

    // Back-to-back 50/5: go is re-presented from the DONE cycle through the
    // following IDLE cycle, and kept low while BUSY.
    issue(32'd50, 32'd5);
    base = 0;
    for (int k = 0; k < 3; k++) begin
      wait_done(1, lat);
      abs_cyc = base + lat;
      chk($sformatf("b2b%0d_done_cycle", k), abs_cyc, 33 + 34 * k);
      chk($sformatf("b2b%0d_quotient", k), out_quotient, 10);
      chk($sformatf("b2b%0d_remainder", k), out_remainder, 0);
      prev_q = 32'd10; prev_r = 32'd0;
      base = abs_cyc + 1;
      if (k < 2) begin
        go = 1'b1; left = 32'd50; right = 32'd5;
        @(posedge clk);
        @(posedge clk); #1;
        go = 1'b0;
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_done_low_after", done, 0);

    // Operands change in cycle 5; the result must come from 100/7.
    issue(32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1 left = 32'd9; right = 32'd3;
    wait_done(5, lat);
    check_result("opchange", 32'd14, 32'd2, lat, 33);

    // Reset in cycle 10 aborts; outputs clear, no done.
    issue(32'd100, 32'd7);
    begin
      bit no_done;
      no_done = 1'b1;
      for (int c = 1; c < 10; c++) begin
        @(negedge clk);
        if (done) no_done = 1'b0;
        @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_quotient_zero", out_quotient, 0);
      chk("abort_remainder_zero", out_remainder, 0);
      chk("abort_done_low", done, 0);
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        @(negedge clk);
        if (done) no_done = 1'b0;
      end
      chk("abort_no_done", no_done, 1);
    end
    prev_q = '0; prev_r = '0;
    run_op("after_abort", 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // Randomized operands against the arithmetic reference.
    for (int i = 0; i < 24; i++) begin
      rl = $urandom;
      case ($urandom_range(0, 3))
        0:       rr = '0;
        1:       rr = W'($urandom_range(1, 15));
        2:       rr = $urandom;
        default: rr = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 4) == 0) rl = rl >> $urandom_range(0, 31);
      run_op($sformatf("rand%0d", i), rl, rr, ref_q(rl, rr), ref_r(rl, rr),
             (rr == 0) ? 1 : W + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
